muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV64M multiply/divide unit. Sits in the execute stage, downstream of the register file.
//   Consumes the two read ports (rs1/rs2 data) and returns a result with its destination register for writeback.
//   Multi-cycle: one shift-add or restoring-subtract step per clock. The pipeline stalls on busy.
// PARAMETERS
//   XLEN  64  datapath width; W-variant ops are defined only for XLEN=64
// PORTS
//   clk         in   1     clock, rising edge
//   reset       in   1     asynchronous, active-high
//   start       in   1     request; accepted on a rising edge when busy=0
//   op          in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   word        in   1     1 = W variant (MULW/DIVW/DIVUW/REMW/REMUW)
//   rs1_data    in   XLEN  operand A (read_data1)
//   rs2_data    in   XLEN  operand B (read_data2)
//   rd_in       in   5     destination register; captured at accept
//   busy        out  1     operation in flight; start ignored while high
//   done        out  1     one-cycle pulse; result/rd_out valid while high
//   result      out  XLEN  result
//   rd_out      out  5     destination register of result
// BEHAVIOUR
//   Reset (any time, including mid-op): state=IDLE, busy=0, done=0, result=0, rd_out=0; in-flight op discarded.
//   States: IDLE -> PREP (1 cycle) -> CALC (N cycles) -> FIN (1 cycle) -> IDLE. N=64 for word=0, N=32 for word=1.
//   Accept at edge E0 (start=1, busy=0): latch op, word, operands, rd_in. busy=1 from E0.
//   Normal latency: done=1 and busy=0 at edge E0+N+2. done drops after one cycle. result/rd_out hold until the next done.
//   Fast path (no CALC): done at edge E0+1. Used for div-by-zero, signed overflow, and illegal word ops.
//   Back-to-back: start may be asserted in the same cycle done=1 (busy=0). It is accepted at that edge.
//   start while busy=1: ignored, no state change.
//   PREP: W ops take operands [31:0], sign-extended for signed ops, zero-extended for DIVUW/REMUW.
//     Signed operands are converted to magnitudes. Sign flags are recorded.
//     MULHSU: rs1 signed, rs2 unsigned.
//   MUL*: 2N-bit shift-add product of magnitudes. Negated in FIN if the operand signs differ.
//     MUL/MULW return the low part. MULH/MULHSU/MULHU return product[127:64].
//   DIV/REM*: restoring division of magnitudes.
//     Quotient is negated if the dividend and divisor signs differ. Remainder takes the dividend's sign.
//   Div by zero: quotient = all ones (-1). Remainder = dividend (W: sign-extended low 32 bits).
//   Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. Applies to DIV/REM, and to DIVW/REMW at 32 bits.
//   word=1 with op 1..3 (illegal): result=0 via fast path.
//   W results: sign-extend bit 31 to 64 bits (includes DIVUW/REMUW).
//   rd_in=0: computed normally. The register file drops the write.
// TESTING
//   1. MUL 7 * 0xFFFF_FFFF_FFFF_FFFD, start at E0, rd_in=5 -> done at E0+66, result=0xFFFF_FFFF_FFFF_FFEB, rd_out=5.
//   2. MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> result=1.
//      MULH -1 * -1 -> result=0.
//      MULHSU -1 * 2 -> result=0xFFFF_FFFF_FFFF_FFFF.
//   3. DIVU 100 / 0 -> result=0xFFFF_FFFF_FFFF_FFFF at E0+1.
//      REM 100 % 0 -> result=100 at E0+1.
//   4. DIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000 (fast).
//      REM on the same operands -> result=0.
//   5. DIVW -7 / 2 -> result=0xFFFF_FFFF_FFFF_FFFD at E0+34.
//      REMW -7 % 2 -> result=0xFFFF_FFFF_FFFF_FFFF.
//      DIVUW 0x1_8000_0000 / 1 -> result=0xFFFF_FFFF_8000_0000.
//   6. reset at E0+10 of a DIV -> busy=0, done=0, result=0 immediately; no done follows.
//      start pulsed while busy -> ignored.
//      start in the done cycle -> accepted; its done arrives at E0'+66.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-subtract step per clock.
module muldiv_unit #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned PW = 2 * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic [2:0]        op_q, op_d;
   logic              word_q, word_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [4:0]        rd_q, rd_d;
   logic [PW-1:0]     acc_q, acc_d;   // product accumulator / remainder in [XLEN-1:0]
   logic [PW-1:0]     x_q, x_d;       // shifted multiplicand / divisor in [XLEN-1:0]
   logic [XLEN-1:0]   y_q, y_d;       // multiplier / dividend shifting into quotient
   logic              neg_q, neg_d;   // product or quotient must be negated
   logic              rneg_q, rneg_d; // remainder takes dividend sign
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              is_div, signed_a, signed_b, neg_a, neg_b;
   logic              illegal, div_zero, ovf;
   logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_neg;
   logic [XLEN:0]     trial, diff;
   logic              ge;
   logic [PW-1:0]     prod;
   logic [XLEN-1:0]   quo, rem, dres;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

   // Operand conditioning and special-case detection on the latched request.
   always_comb begin
      is_div   = op_q[2];
      signed_a = (op_q != 3'd3) && (op_q != 3'd5) && (op_q != 3'd7);
      signed_b = signed_a && (op_q != 3'd2);
      ext_a    = word_q ? (signed_a ? sext32(a_q) : {{(XLEN-32){1'b0}}, a_q[31:0]}) : a_q;
      ext_b    = word_q ? (signed_b ? sext32(b_q) : {{(XLEN-32){1'b0}}, b_q[31:0]}) : b_q;
      neg_a    = signed_a && ext_a[XLEN-1];
      neg_b    = signed_b && ext_b[XLEN-1];
      mag_a    = neg_a ? -ext_a : ext_a;
      mag_b    = neg_b ? -ext_b : ext_b;
      min_neg  = word_q ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
      illegal  = word_q && !is_div && (op_q != 3'd0);
      div_zero = is_div && (ext_b == '0);
      ovf      = is_div && signed_b && (ext_a == min_neg) && (ext_b == '1);
   end

   // Restoring-division trial subtract and final sign correction.
   always_comb begin
      trial = {acc_q[XLEN-1:0], y_q[XLEN-1]};
      diff  = trial - {1'b0, x_q[XLEN-1:0]};
      ge    = (trial >= {1'b0, x_q[XLEN-1:0]});
      prod  = neg_q ? -acc_q : acc_q;
      quo   = neg_q ? -y_q : y_q;
      rem   = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      dres  = op_q[1] ? rem : quo;
   end

   // Next-state, datapath and output logic.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
      op_d     = op_q;
      word_d   = word_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      acc_d    = acc_q;
      x_d      = x_q;
      y_d      = y_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               word_d  = word;
               a_d     = rs1_data;
               b_d     = rs2_data;
               rd_d    = rd_in;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            if (illegal || div_zero || ovf) begin
               done_d   = 1'b1;
               rd_out_d = rd_q;
               state_d  = S_IDLE;
               if (illegal)
                  result_d = '0;
               else if (div_zero)
                  result_d = op_q[1] ? (word_q ? sext32(a_q) : a_q) : '1;
               else
                  result_d = op_q[1] ? '0 : ext_a;
            end else begin
               acc_d   = '0;
               x_d     = {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
               y_d     = is_div ? (word_q ? (mag_a << 32) : mag_a) : mag_b;
               neg_d   = neg_a ^ neg_b;
               rneg_d  = neg_a;
               cnt_d   = word_q ? CW'(31) : CW'(XLEN-1);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (!is_div) begin
               if (y_q[0])
                  acc_d = acc_q + x_q;
               x_d = x_q << 1;
               y_d = y_q >> 1;
            end else begin
               acc_d = {{XLEN{1'b0}}, ge ? diff[XLEN-1:0] : trial[XLEN-1:0]};
               y_d   = {y_q[XLEN-2:0], ge};
            end
            if (cnt_q == '0)
               state_d = S_FIN;
            else
               cnt_d = cnt_q - CW'(1);
         end
         S_FIN: begin
            done_d   = 1'b1;
            rd_out_d = rd_q;
            state_d  = S_IDLE;
            if (is_div)
               result_d = word_q ? sext32(dres) : dres;
            else if (op_q == 3'd0)
               result_d = word_q ? sext32(prod[XLEN-1:0]) : prod[XLEN-1:0];
            else
               result_d = prod[PW-1:XLEN];
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         acc_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
         op_q     <= op_d;
         word_q   <= word_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, fast paths, reset and back-to-back issue.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        word;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [4:0]  rd_out;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.XLEN(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .word     (word),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op from a negedge; return at the negedge of its done cycle.
   task automatic run(input string tag, input logic [2:0] o, input logic w,
                      input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                      input logic [63:0] exp_r, input int exp_lat, input bit poke);
      int lat;
      bit seen;
      op = o; word = w; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 3'd0; word = ~w; rs1_data = ~a; rs2_data = ~b; rd_in = ~rd;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         start = (poke && lat == 4);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_done"}, 64'(seen), 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_rd"}, 64'(rd_out), 64'(rd));
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   // One cycle later: done has dropped, outputs hold.
   task automatic hold_chk(input string tag, input logic [63:0] exp_r, input logic [4:0] rd);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_drop"}, 64'(done), 64'd0);
      chk({tag, "_hold_result"}, result, exp_r);
      chk({tag, "_hold_rd"}, 64'(rd_out), 64'(rd));
   endtask

   initial begin
      int dcount;
      reset = 1'b1; start = 1'b0; op = '0; word = 1'b0;
      rs1_data = '0; rs2_data = '0; rd_in = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_rd", 64'(rd_out), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66, 1'b0);
      hold_chk("mul", 64'hFFFF_FFFF_FFFF_FFEB, 5'd5);

      run("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'd1, 66, 1'b0);
      run("mulh", 3'd1, 1'b0, '1, '1, 5'd7, 64'd0, 66, 1'b0);
      run("mulhsu", 3'd2, 1'b0, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0);
      run("divu_z", 3'd5, 1'b0, 64'd100, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      run("rem_z", 3'd6, 1'b0, 64'd100, 64'd0, 5'd10, 64'd100, 1, 1'b0);
      run("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 64'h8000_0000_0000_0000, 1, 1'b0);
      run("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd12, 64'd0, 1, 1'b0);
      run("divw", 3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b0);
      run("remw", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
      run("divuw", 3'd5, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 5'd15, 64'hFFFF_FFFF_8000_0000, 34, 1'b0);
      run("mulw", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0);
      run("mulhw_ill", 3'd1, 1'b1, 64'd5, 64'd6, 5'd17, 64'd0, 1, 1'b0);
      run("divw_ovf", 3'd4, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd18,
          64'hFFFF_FFFF_8000_0000, 1, 1'b0);
      run("remuw_z", 3'd7, 1'b1, 64'h0000_0000_9000_0000, 64'h0000_0001_0000_0000, 5'd19,
          64'hFFFF_FFFF_9000_0000, 1, 1'b0);
      run("div_neg", 3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd20, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1'b0);
      run("rem_neg", 3'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd21, 64'd2, 66, 1'b0);
      run("remu_poke", 3'd7, 1'b0, 64'd1000, 64'd7, 5'd22, 64'd6, 66, 1'b1);
      run("mul_rd0", 3'd0, 1'b0, 64'd3, 64'd4, 5'd0, 64'd12, 66, 1'b0);
      hold_chk("mul_rd0", 64'd12, 5'd0);

      // Reset ten edges into a divide.
      op = 3'd4; word = 1'b0; rs1_data = 64'd1000; rs2_data = 64'd3; rd_in = 5'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_result", result, 64'd0);
      chk("midrst_rd", 64'(rd_out), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("midrst_no_done", 64'(dcount), 64'd0);
      chk("midrst_idle", 64'(busy), 64'd0);

      // Second op issued in the done cycle of the first.
      run("b2b_a", 3'd0, 1'b0, 64'd6, 64'd7, 5'd9, 64'd42, 66, 1'b0);
      run("b2b_b", 3'd5, 1'b0, 64'd1000, 64'd10, 5'd10, 64'd100, 66, 1'b0);
      hold_chk("b2b_b", 64'd100, 5'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
